// File: rtl/lemming_array_fsm.sv
// N independent lemming walker FSMs with a registered alive count.
// Optional LEMMING_SPLAT_STATS_EN adds splat_count_o, a saturating count of deaths.
module lemming_array_fsm #(
  parameter int N          = 4,
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = 8,
  parameter int DIG_MAX    = 0
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [N-1:0]             bump_left_i,
  input  logic [N-1:0]             bump_right_i,
  input  logic [N-1:0]             ground_i,
  input  logic [N-1:0]             dig_i,
  input  logic [N-1:0]             revive_i,
  output logic [N-1:0]             walk_left_o,
  output logic [N-1:0]             walk_right_o,
  output logic [N-1:0]             aaah_o,
  output logic [N-1:0]             digging_o,
  output logic [N-1:0]             dead_o,
  output logic [$clog2(N+1)-1:0]   alive_count_o,
`ifdef LEMMING_SPLAT_STATS_EN
  output logic [15:0]              splat_count_o,
`endif
  output logic [3*N-1:0]           lane_state_o
);
  localparam int AW = $clog2(N+1);
  localparam logic [CNT_W-1:0] FALL_LIM_C = CNT_W'(FALL_LIMIT);
  localparam logic [CNT_W-1:0] DIG_LAST_C = (DIG_MAX == 0) ? '0 : CNT_W'(DIG_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = '1;
  localparam bit DIG_LIMITED = (DIG_MAX != 0);

  typedef enum logic [2:0] {
    ST_WL    = 3'd0,
    ST_WR    = 3'd1,
    ST_FALLL = 3'd2,
    ST_FALLR = 3'd3,
    ST_DIGL  = 3'd4,
    ST_DIGR  = 3'd5,
    ST_DEAD  = 3'd6
  } state_e;

  state_e           state_q [N];
  state_e           state_d [N];
  logic [CNT_W-1:0] fcnt_q  [N];
  logic [CNT_W-1:0] fcnt_d  [N];
  logic [CNT_W-1:0] dcnt_q  [N];
  logic [CNT_W-1:0] dcnt_d  [N];
  logic [AW-1:0]    alive_d;
`ifdef LEMMING_SPLAT_STATS_EN
  logic [5:0]       deaths_d;
`endif

  always_comb begin
    alive_d = '0;
`ifdef LEMMING_SPLAT_STATS_EN
    deaths_d = '0;
`endif
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      fcnt_d[i]  = '0;
      dcnt_d[i]  = '0;
      case (state_q[i])
        ST_WL: begin
          if (!ground_i[i])        state_d[i] = ST_FALLL;
          else if (dig_i[i])       state_d[i] = ST_DIGL;
          else if (bump_left_i[i]) state_d[i] = ST_WR;
        end
        ST_WR: begin
          if (!ground_i[i])         state_d[i] = ST_FALLR;
          else if (dig_i[i])        state_d[i] = ST_DIGR;
          else if (bump_right_i[i]) state_d[i] = ST_WL;
        end
        ST_FALLL, ST_FALLR: begin
          // fcnt saturates at the limit so a long fall can never wrap back to "safe"
          if (!ground_i[i])
            fcnt_d[i] = (fcnt_q[i] == FALL_LIM_C) ? fcnt_q[i] : fcnt_q[i] + 1'b1;
          else if (fcnt_q[i] >= FALL_LIM_C)
            state_d[i] = ST_DEAD;
          else
            state_d[i] = (state_q[i] == ST_FALLL) ? ST_WL : ST_WR;
        end
        ST_DIGL, ST_DIGR: begin
          if (!ground_i[i])
            state_d[i] = (state_q[i] == ST_DIGL) ? ST_FALLL : ST_FALLR;
          else if (DIG_LIMITED && (dcnt_q[i] == DIG_LAST_C))
            state_d[i] = (state_q[i] == ST_DIGL) ? ST_WL : ST_WR;
          else
            dcnt_d[i] = (dcnt_q[i] == CNT_MAX_C) ? dcnt_q[i] : dcnt_q[i] + 1'b1;
        end
        ST_DEAD: begin
          if (revive_i[i]) state_d[i] = ST_WL;
        end
        default: state_d[i] = ST_WL;
      endcase
      if (state_d[i] != ST_DEAD) alive_d = alive_d + AW'(1);
`ifdef LEMMING_SPLAT_STATS_EN
      if ((state_d[i] == ST_DEAD) && (state_q[i] != ST_DEAD)) deaths_d = deaths_d + 6'd1;
`endif
    end
  end

  // Outputs are registered decodes of the next state, so they track state_q exactly.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_WL;
        fcnt_q[i]  <= '0;
        dcnt_q[i]  <= '0;
      end
      walk_left_o   <= '1;
      walk_right_o  <= '0;
      aaah_o        <= '0;
      digging_o     <= '0;
      dead_o        <= '0;
      alive_count_o <= AW'(N);
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i]      <= state_d[i];
        fcnt_q[i]       <= fcnt_d[i];
        dcnt_q[i]       <= dcnt_d[i];
        walk_left_o[i]  <= (state_d[i] == ST_WL);
        walk_right_o[i] <= (state_d[i] == ST_WR);
        aaah_o[i]       <= (state_d[i] == ST_FALLL) || (state_d[i] == ST_FALLR);
        digging_o[i]    <= (state_d[i] == ST_DIGL) || (state_d[i] == ST_DIGR);
        dead_o[i]       <= (state_d[i] == ST_DEAD);
      end
      alive_count_o <= alive_d;
    end
  end

`ifdef LEMMING_SPLAT_STATS_EN
  logic [16:0] splat_sum;
  assign splat_sum = {1'b0, splat_count_o} + 17'(deaths_d);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) splat_count_o <= '0;
    else        splat_count_o <= splat_sum[16] ? 16'hFFFF : splat_sum[15:0];
  end
`endif

  always_comb begin
    lane_state_o = '0;
    for (int i = 0; i < N; i++) lane_state_o[3*i +: 3] = state_q[i];
  end
endmodule

// File: doc/lemming_array_fsm.md
Name: lemming_array_fsm

Overview:
- N independent lemming walker controllers in one block, each a Moore FSM: walk left/right, fall, dig, dead.
- Generalises the single-lemming controller:
  - parametrised lane count, fall-death threshold and dig budget;
  - per-lane revive from the dead state;
  - aggregated alive count.
- Sits in the game-logic layer; one lane per on-screen lemming, driven by per-lane terrain/collision inputs.

Parameters:
- N, 4, number of lemming lanes (1..32).
- FALL_LIMIT, 20, landing after more than FALL_LIMIT fall cycles kills the lane (1..255).
- CNT_W, 8, fall/dig counter width; must hold max(FALL_LIMIT, DIG_MAX).
- DIG_MAX, 0, consecutive dig-cycle budget; 0 = unlimited.

Ports:
- clk  in  1  clock, rising edge.
- areset  in  1  reset; asynchronous, active-high; all lanes to walk-left.
- bump_left  in  N  per-lane left obstacle.
- bump_right  in  N  per-lane right obstacle.
- ground  in  N  per-lane ground present.
- dig  in  N  per-lane dig request.
- revive  in  N  per-lane synchronous revive; honoured only in DEAD.
- walk_left  out  N  lane in WL.
- walk_right  out  N  lane in WR.
- aaah  out  N  lane in FALLL or FALLR.
- digging  out  N  lane in DIGL or DIGR.
- dead  out  N  lane in DEAD.
- alive_count  out  $clog2(N+1)  number of lanes not in DEAD, registered.

Behaviour:
- Reset (async):
  - every lane state=WL, counters=0, alive_count=N.
  - outputs: walk_left=all ones; walk_right, aaah, digging, dead all zero.
- Outputs are pure decode of the current state, so they change one clk after the causing input. Exactly one of walk_left/walk_right/aaah/digging/dead is set per lane.
- Per-lane transitions; priority is top to bottom within each state:
  - WL:
    - !ground -> FALLL;
    - dig -> DIGL;
    - bump_left -> WR;
    - else WL.
    - bump_right is ignored in WL.
  - WR: mirror of WL (FALLR, DIGR, bump_right -> WL).
  - FALLL/FALLR:
    - !ground -> stay;
    - ground and fcnt>=FALL_LIMIT -> DEAD;
    - ground and fcnt<FALL_LIMIT -> WL/WR (direction preserved).
    - bumps and dig are ignored while falling.
  - DIGL/DIGR:
    - !ground -> FALLL/FALLR;
    - else if DIG_MAX!=0 and dcnt==DIG_MAX-1 -> WL/WR;
    - else stay.
  - DEAD: revive -> WL, else stay. All other inputs are ignored.
- Fall counter fcnt, per lane:
  - 0 in any non-fall state.
  - In a fall state it increments each cycle and saturates at FALL_LIMIT; it never wraps.
  - fcnt is 0 on the first fall cycle, so a lane dies when it lands after spending more than FALL_LIMIT cycles in a fall state.
- Dig counter dcnt, per lane: 0 outside dig states; increments each dig cycle; saturating.
- alive_count: registered population count of next-state != DEAD, so it updates on the same edge as the lane states.
- Simultaneous events: lanes are fully independent; any mix of deaths and revives on one edge is counted exactly.
- areset mid-fall or mid-dig: the lane returns to WL immediately and counters clear; no death is recorded.

Optional Feature:
- Macro: LEMMING_SPLAT_STATS_EN.
- Defined:
  - adds output splat_count [15:0], an accumulated count of lane transitions into DEAD.
  - Adds the number of lanes entering DEAD each cycle; saturates at 16'hFFFF.
  - Cleared by areset only; revive does not clear it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then lane0 bump_left=1 for one cycle:
  - lane0 walk_right=1 next cycle;
  - other lanes stay walk_left;
  - alive_count=4.
- Lane1 ground=0 for exactly 20 cycles, then ground=1:
  - aaah=1 for 20 cycles;
  - then walk_left=1.
  - Repeat with 21 cycles -> dead[1]=1, alive_count=3.
- Lane2 in WR with dig=1 and DIG_MAX=5:
  - digging=1 for 5 cycles, then walk_right=1.
  - Repeat with ground dropped on dig cycle 3 -> aaah=1, then walk_right on landing.
- All lanes fall 25 cycles and land on the same edge:
  - dead=4'hF, alive_count=0, splat_count=4 (macro on).
  - Assert revive=4'h5 -> lanes 0,2 walk_left, alive_count=2.
- areset asserted mid-fall (lane3 fall cycle 15), released asynchronously:
  - lane3 walk_left immediately;
  - a subsequent 20-cycle fall survives, proving fcnt cleared.
